// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared types and constants for the register-file writeback arbiter.
// Optional build macro used by the top level: RFARB_ROUND_ROBIN_EN.
package rfarb_pkg;

    localparam int DATA_W = 64;
    localparam int ADDR_W = 5;
    localparam logic [ADDR_W-1:0] ZERO_REG = ADDR_W'(31);

    // One queued register-file write.
    typedef struct packed {
        logic [ADDR_W-1:0] rw;
        logic [DATA_W-1:0] data;
    } wb_entry_t;

    // Which requester wins the next contention in round-robin builds.
    typedef enum logic {
        RR_REQ0 = 1'b0,
        RR_REQ1 = 1'b1
    } rr_t;

    // Writes to the hard-wired zero register never reach the register file.
    function automatic logic is_zero_reg(input logic [ADDR_W-1:0] idx);
        return idx == ZERO_REG;
    endfunction

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Bus bundle between the two writeback requesters, the hazard check
// and the register-file write port.
//
// Handshake: a requester write transfers on a rising clock edge when
// ReqN_Valid and ReqN_Ready are both high. ReqN_Ready depends only on the
// FIFO fill level before that edge, never on ReqN_Valid; ReqN_RW/ReqN_Data
// must be held stable while ReqN_Valid is high and not yet accepted.
interface regfile_wb_arbiter_if;
    import rfarb_pkg::*;

    logic              Req0_Valid;
    logic              Req0_Ready;
    logic [ADDR_W-1:0] Req0_RW;
    logic [DATA_W-1:0] Req0_Data;
    logic              Req1_Valid;
    logic              Req1_Ready;
    logic [ADDR_W-1:0] Req1_RW;
    logic [DATA_W-1:0] Req1_Data;
    logic              RegWr;
    logic [ADDR_W-1:0] RW;
    logic [DATA_W-1:0] BusW;
    logic [ADDR_W-1:0] Chk_RA;
    logic [ADDR_W-1:0] Chk_RB;
    logic              Pend_A;
    logic              Pend_B;
    logic              Idle;

    // Pipeline side: requesters, hazard check and register file.
    modport master (
        output Req0_Valid, Req0_RW, Req0_Data,
        output Req1_Valid, Req1_RW, Req1_Data,
        output Chk_RA, Chk_RB,
        input  Req0_Ready, Req1_Ready,
        input  RegWr, RW, BusW,
        input  Pend_A, Pend_B, Idle
    );

    // Arbiter side.
    modport slave (
        input  Req0_Valid, Req0_RW, Req0_Data,
        input  Req1_Valid, Req1_RW, Req1_Data,
        input  Chk_RA, Chk_RB,
        output Req0_Ready, Req1_Ready,
        output RegWr, RW, BusW,
        output Pend_A, Pend_B, Idle
    );

endinterface

// File: rtl/regfile_wb_arbiter_fifo.sv
// Small synchronous FIFO of writeback entries. Besides the head it exposes
// which slots hold live entries and the destination index of every slot so
// the top level can flag pending writes without popping anything.
module rfarb_fifo
    import rfarb_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  wb_entry_t                push_entry,
    input  logic                     pop,
    output logic                     full,
    output logic                     empty,
    output wb_entry_t                head,
    output logic [DEPTH-1:0]         ent_valid,
    output logic [DEPTH*ADDR_W-1:0]  ent_rw
);

    localparam int PTR_W = $clog2(DEPTH);

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [PTR_W:0]   wr_ptr;
    logic [PTR_W:0]   rd_ptr;
    logic [PTR_W:0]   count;
    logic [PTR_W-1:0] offs;
    wb_entry_t        mem [DEPTH];

    assign count = wr_ptr - rd_ptr;
    assign full  = (count == (PTR_W+1)'(DEPTH));
    assign empty = (count == '0);
    assign head  = mem[rd_ptr[PTR_W-1:0]];

    // Advance pointers; callers only push when not full and pop when not empty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Entry storage; contents of dead slots are masked by ent_valid.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[PTR_W-1:0]] <= push_entry;
    end

    // A slot is live when its distance from the read pointer is below the fill count.
    always_comb begin
        ent_valid = '0;
        ent_rw    = '0;
        offs      = '0;
        for (int i = 0; i < DEPTH; i++) begin
            offs         = PTR_W'(i) - rd_ptr[PTR_W-1:0];
            ent_valid[i] = ({1'b0, offs} < count);
            ent_rw[i*ADDR_W +: ADDR_W] = mem[i].rw;
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the register file's single write port between load writeback
// (requester 0) and ALU writeback (requester 1). Each requester has its own
// FIFO; one head per cycle is popped and registered onto RegWr/RW/BusW.
// Pend_A/Pend_B tell the hazard logic a write to Chk_RA/Chk_RB is in flight.
// Build macro RFARB_ROUND_ROBIN_EN: two-way round robin when defined,
// fixed priority to requester 0 otherwise.
module regfile_wb_arbiter
    import rfarb_pkg::*;
#(
    parameter int FIFO_DEPTH = 2
) (
    input  logic                Clk,
    input  logic                Rst_n,
    regfile_wb_arbiter_if.slave bus
);

    logic                         full0, empty0, full1, empty1;
    logic                         ready0, ready1;
    logic                         push0, push1;
    logic                         pop0, pop1;
    logic                         has0, has1, sel1, grant_any;
    wb_entry_t                    in0, in1, head0, head1, grant_entry;
    logic [FIFO_DEPTH-1:0]        valid0, valid1;
    logic [FIFO_DEPTH*ADDR_W-1:0] rw_flat0, rw_flat1;
    logic                         reg_wr_q;
    logic [ADDR_W-1:0]            rw_q;
    logic [DATA_W-1:0]            bus_w_q;
    logic                         pend_a, pend_b;

    // Ready is held low during reset so nothing is accepted while flushed.
    assign ready0 = Rst_n && !full0;
    assign ready1 = Rst_n && !full1;
    assign push0  = bus.Req0_Valid && ready0;
    assign push1  = bus.Req1_Valid && ready1;

    assign in0.rw   = bus.Req0_RW;
    assign in0.data = bus.Req0_Data;
    assign in1.rw   = bus.Req1_RW;
    assign in1.data = bus.Req1_Data;

    rfarb_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo0 (
        .clk        (Clk),
        .rst_n      (Rst_n),
        .push       (push0),
        .push_entry (in0),
        .pop        (pop0),
        .full       (full0),
        .empty      (empty0),
        .head       (head0),
        .ent_valid  (valid0),
        .ent_rw     (rw_flat0)
    );

    rfarb_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo1 (
        .clk        (Clk),
        .rst_n      (Rst_n),
        .push       (push1),
        .push_entry (in1),
        .pop        (pop1),
        .full       (full1),
        .empty      (empty1),
        .head       (head1),
        .ent_valid  (valid1),
        .ent_rw     (rw_flat1)
    );

`ifdef RFARB_ROUND_ROBIN_EN
    rr_t rr_q;

    // Point at the requester that was not just served.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            rr_q <= RR_REQ0;
        end else if (pop0) begin
            rr_q <= RR_REQ1;
        end else if (pop1) begin
            rr_q <= RR_REQ0;
        end
    end
`endif

    // Pick one non-empty head per cycle and pop it.
    always_comb begin
        has0 = !empty0;
        has1 = !empty1;
`ifdef RFARB_ROUND_ROBIN_EN
        if (has0 && has1) begin
            sel1 = (rr_q == RR_REQ1);
        end else begin
            sel1 = has1;
        end
`else
        sel1 = has1 && !has0;
`endif
        pop0        = has0 && !sel1;
        pop1        = has1 && sel1;
        grant_any   = has0 || has1;
        grant_entry = sel1 ? head1 : head0;
    end

    // Register the granted entry; zero-register writes load RW/BusW but keep RegWr low.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            reg_wr_q <= 1'b0;
            rw_q     <= '0;
            bus_w_q  <= '0;
        end else if (grant_any) begin
            reg_wr_q <= !is_zero_reg(grant_entry.rw);
            rw_q     <= grant_entry.rw;
            bus_w_q  <= grant_entry.data;
        end else begin
            reg_wr_q <= 1'b0;
        end
    end

    // Flag reads whose index matches any queued entry or the write on the port now.
    always_comb begin
        pend_a = 1'b0;
        pend_b = 1'b0;
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            if (valid0[i] && (rw_flat0[i*ADDR_W +: ADDR_W] == bus.Chk_RA)) pend_a = 1'b1;
            if (valid1[i] && (rw_flat1[i*ADDR_W +: ADDR_W] == bus.Chk_RA)) pend_a = 1'b1;
            if (valid0[i] && (rw_flat0[i*ADDR_W +: ADDR_W] == bus.Chk_RB)) pend_b = 1'b1;
            if (valid1[i] && (rw_flat1[i*ADDR_W +: ADDR_W] == bus.Chk_RB)) pend_b = 1'b1;
        end
        if (reg_wr_q && (rw_q == bus.Chk_RA)) pend_a = 1'b1;
        if (reg_wr_q && (rw_q == bus.Chk_RB)) pend_b = 1'b1;
        if (is_zero_reg(bus.Chk_RA)) pend_a = 1'b0;
        if (is_zero_reg(bus.Chk_RB)) pend_b = 1'b0;
    end

    assign bus.Req0_Ready = ready0;
    assign bus.Req1_Ready = ready1;
    assign bus.RegWr      = reg_wr_q;
    assign bus.RW         = rw_q;
    assign bus.BusW       = bus_w_q;
    assign bus.Pend_A     = pend_a;
    assign bus.Pend_B     = pend_b;
    assign bus.Idle       = empty0 && empty1 && !reg_wr_q;

endmodule
